// File: rtl/l2_dport_master.sv
// Requester-side controller for one L2 line data array port: line reads with a
// held response, and byte-masked writes posted through an in-order write buffer.
module l2_dport_master #(
    parameter int unsigned NUM_COL    = 16,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int unsigned WB_DEPTH   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [NUM_COL-1:0]    req_be_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  mem_we_o,
    output logic [NUM_COL-1:0]    mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  wb_empty_o
);

    localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_CAPT,
        S_RSP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_wb_addr [WB_DEPTH];
    logic [NUM_COL-1:0]    r_wb_be   [WB_DEPTH];
    logic [DATA_WIDTH-1:0] r_wb_data [WB_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  r_mem_we;
    logic [NUM_COL-1:0]    r_mem_be;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic             w_full;
    logic             w_empty;
    logic             w_wb_hit;
    logic [PTR_W-1:0] w_off;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CNT_W'(WB_DEPTH));
    assign w_empty = (r_count == '0);

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        w_wb_hit = 1'b0;
        w_off    = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            w_off = PTR_W'(i) - r_rd_ptr;
            if ((CNT_W'(w_off) < r_count) && (r_wb_addr[i] == req_addr_i)) begin
                w_wb_hit = 1'b1;
            end
        end
    end

    assign req_ready_o = req_we_i ? !w_full : ((r_state == S_IDLE) && !w_wb_hit);
    assign w_rd_acc    = req_valid_i && !req_we_i && (r_state == S_IDLE) && !w_wb_hit;
    assign w_wr_acc    = req_valid_i && req_we_i && !w_full;
    assign w_push      = w_wr_acc && (req_be_i != '0);
    assign w_pop       = !w_rd_acc && !w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_rd_acc) w_state_nxt = S_RD_ISSUE;
            S_RD_ISSUE: w_state_nxt = S_RD_CAPT;
            S_RD_CAPT:  w_state_nxt = S_RSP;
            S_RSP:      if (rsp_ready_i) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_wb_addr[r_wr_ptr] <= req_addr_i;
            r_wb_be[r_wr_ptr]   <= req_be_i;
            r_wb_data[r_wr_ptr] <= req_data_i;
        end
    end

    // A read issue owns the array port on its acceptance edge; drains take every other edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem_we   <= 1'b0;
            r_mem_be   <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else if (w_rd_acc) begin
            r_mem_we   <= 1'b0;
            r_mem_be   <= '0;
            r_mem_addr <= req_addr_i;
        end else if (w_pop) begin
            r_mem_we   <= 1'b1;
            r_mem_be   <= r_wb_be[r_rd_ptr];
            r_mem_addr <= r_wb_addr[r_rd_ptr];
            r_mem_data <= r_wb_data[r_rd_ptr];
        end else begin
            r_mem_we <= 1'b0;
            r_mem_be <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else if (r_state == S_RD_CAPT) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= mem_data_i;
        end else if ((r_state == S_RSP) && rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_addr_o  = r_mem_addr;
    assign mem_data_o  = r_mem_data;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign wb_empty_o  = w_empty && !r_mem_we;

endmodule

// File: tb/tb_l2_dport_master.sv
// Bench for l2_dport_master: a bench-owned line array as responder, and a
// transaction-level model (shadow memory, pending-write queue, read age).
module tb_l2_dport_master;

    localparam int unsigned NC = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 128;
    localparam int unsigned WD = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready_o;
    logic          req_we = 1'b0;
    logic [NC-1:0] req_be = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          rsp_valid_o;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data_o;
    logic          mem_we_o;
    logic [NC-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i = '0;
    logic          wb_empty_o;

    l2_dport_master #(
        .NUM_COL(NC), .COL_WIDTH(8), .ADDR_WIDTH(AW), .WB_DEPTH(WD)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_be_i(req_be), .req_addr_i(req_addr), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .wb_empty_o(wb_empty_o)
    );

    always #5 clk_i = ~clk_i;

    // Responder: registered, read-first line array with byte enables.
    logic [DW-1:0] mem [256];
    always @(posedge clk_i) begin
        logic [DW-1:0] rd;
        rd = mem[mem_addr_o];
        if (mem_we_o) begin
            for (int b = 0; b < NC; b++) begin
                if (mem_be_o[b]) mem[mem_addr_o][b*8 +: 8] = mem_data_o[b*8 +: 8];
            end
        end
        mem_data_i <= rd;
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [NC-1:0] be;
        logic [DW-1:0] d;
    } ent_t;

    logic [DW-1:0] shadow [256];
    ent_t          wq [$];
    bit            rd_busy;
    int            rd_age;
    logic [DW-1:0] rd_exp;
    logic [AW-1:0] rd_a;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [AW-1:0] a);
        foreach (wq[i]) if (wq[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: entered and left at a negedge with inputs already driven.
    task automatic step(output bit acc);
        bit   exp_rdy, rd_now, exp_drain, rsp_fire, exp_rv;
        ent_t dr;
        #1;
        exp_rdy = req_we ? (wq.size() < WD) : (!rd_busy && !hit(req_addr));
        chk("req_ready", DW'(req_ready_o), DW'(exp_rdy));
        acc       = req_valid && exp_rdy;
        rd_now    = acc && !req_we;
        exp_drain = (wq.size() != 0) && !rd_now;
        if (exp_drain) dr = wq[0];
        rsp_fire  = rd_busy && (rd_age >= 2) && rsp_ready;
        @(posedge clk_i);
        if (exp_drain) void'(wq.pop_front());
        if (acc && req_we && (req_be != '0)) begin
            wq.push_back('{a: req_addr, be: req_be, d: req_data});
            for (int b = 0; b < NC; b++) begin
                if (req_be[b]) shadow[req_addr][b*8 +: 8] = req_data[b*8 +: 8];
            end
        end
        if (rsp_fire) rd_busy = 1'b0;
        else if (rd_busy) rd_age++;
        if (rd_now) begin
            rd_busy = 1'b1;
            rd_age  = 0;
            rd_exp  = shadow[req_addr];
            rd_a    = req_addr;
        end
        @(negedge clk_i);
        chk("mem_we", DW'(mem_we_o), DW'(exp_drain));
        if (exp_drain) begin
            chk("drain_addr", DW'(mem_addr_o), DW'(dr.a));
            chk("drain_be", DW'(mem_be_o), DW'(dr.be));
            chk("drain_data", mem_data_o, dr.d);
        end else begin
            chk("idle_be", DW'(mem_be_o), '0);
        end
        if (rd_now) chk("rd_addr", DW'(mem_addr_o), DW'(rd_a));
        exp_rv = rd_busy && (rd_age >= 2);
        chk("rsp_valid", DW'(rsp_valid_o), DW'(exp_rv));
        if (exp_rv) chk("rsp_data", rsp_data_o, rd_exp);
        chk("wb_empty", DW'(wb_empty_o), DW'((wq.size() == 0) && !exp_drain));
    endtask

    task automatic xfer(input bit we, input logic [NC-1:0] be, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit rr);
        bit acc;
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = a; req_data = d;
        rsp_ready = rr;
        acc = 1'b0;
        for (int i = 0; i < 30 && !acc; i++) step(acc);
        if (!acc) chk("xfer_timeout", DW'(acc), DW'(1));
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit rr);
        bit acc;
        req_valid = 1'b0;
        rsp_ready = rr;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_mem_we", DW'(mem_we_o), '0);
        chk("rst_mem_be", DW'(mem_be_o), '0);
        chk("rst_mem_addr", DW'(mem_addr_o), '0);
        chk("rst_mem_data", mem_data_o, '0);
        chk("rst_rsp_valid", DW'(rsp_valid_o), '0);
        chk("rst_rsp_data", rsp_data_o, '0);
        chk("rst_wb_empty", DW'(wb_empty_o), DW'(1));
        // Dropped writes never reach the array, so the architectural view is the array itself.
        wq.delete();
        rd_busy = 1'b0;
        rd_age  = 0;
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        bit acc;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = {$urandom, $urandom, $urandom, $urandom};
            shadow[i] = mem[i];
        end
        @(negedge clk_i);
        do_reset();

        xfer(1'b1, 16'h0003, 8'h05, {112'h0, 16'hAABB}, 1'b1);
        idle(2, 1'b1);
        xfer(1'b0, '0, 8'h05, '0, 1'b1);
        idle(4, 1'b1);

        xfer(1'b1, 16'hFFFF, 8'h10, {4{32'h1010_1010}}, 1'b1);
        xfer(1'b1, 16'hFFFF, 8'h11, {4{32'h1111_1111}}, 1'b1);
        xfer(1'b1, 16'h00F0, 8'h12, {4{32'h1212_1212}}, 1'b1);
        idle(3, 1'b1);

        xfer(1'b1, 16'hF00F, 8'h20, {4{32'hCAFE_2020}}, 1'b1);
        xfer(1'b0, '0, 8'h20, '0, 1'b1);
        idle(4, 1'b1);

        xfer(1'b0, '0, 8'h30, '0, 1'b0);
        idle(2, 1'b0);
        xfer(1'b1, 16'h8001, 8'h31, {4{32'h3131_3131}}, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(acc);
        xfer(1'b0, '0, 8'h40, '0, 1'b1);
        idle(4, 1'b1);

        xfer(1'b1, 16'h0000, 8'h50, {4{32'hDEAD_BEEF}}, 1'b1);
        idle(3, 1'b1);

        xfer(1'b1, 16'hFFFF, 8'h60, {4{32'h6060_6060}}, 1'b1);
        do_reset();
        idle(3, 1'b1);
        xfer(1'b0, '0, 8'h60, '0, 1'b1);
        idle(4, 1'b1);

        for (int n = 0; n < 800; n++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = $urandom_range(0, 1) != 0;
            req_addr  = AW'($urandom_range(0, 7));
            req_be    = ($urandom_range(0, 7) == 0) ? '0 : NC'($urandom);
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready = ($urandom_range(0, 2) != 0);
            step(acc);
        end
        idle(4, 1'b1);
        for (int a = 0; a < 8; a++) begin
            xfer(1'b0, '0, AW'(a), '0, 1'b1);
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
